frame_capture_writer: RTL
=========================

# frame_capture_writer

Captures one frame of a 24-bit RGB pixel stream into the 6-bit-per-pixel image memory that the display path reads from. It quantizes each pixel to a 6-bit colour index, generates linear raster write addresses, and drives a single BRAM write port. It sits between a video source (camera or test-pattern generator) and the image RAM. It is armed per frame by a request pulse and signals completion or a short-frame error.

## Interface
Parameters:
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_W, 17, write-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- pixel_clk  in  1  single clock for the whole block
- rst_n  in  1  reset; asynchronous, active-low
- capture_req  in  1  one-cycle pulse that arms capture of the next frame
- frame_start  in  1  one-cycle pulse marking the start of a source frame
- pix_valid  in  1  pix_data is valid this cycle
- pix_data  in  24  {R[7:0], G[7:0], B[7:0]}
- we  out  1  image RAM write enable
- waddr  out  ADDR_W  image RAM write address, row*WIDTH + col
- wdata  out  6  colour index {R[7:6], G[7:6], B[7:6]}
- busy  out  1  high in ARMED and CAPTURE
- done  out  1  one-cycle pulse when a full frame has been written
- short_frame  out  1  sticky flag; cleared by the next accepted capture_req

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - capture_req moves to ARMED and clears short_frame.
  - pix_valid and frame_start are ignored.
- ARMED:
  - Waits for frame_start. On frame_start, clear the address counter and go to CAPTURE.
  - If pix_valid is high in the same cycle as frame_start, that pixel is written at address 0.
- CAPTURE: each pix_valid writes one pixel at the current address, then the address increments.
  - The address is a running counter; no multiplier.
  - The col/row counters exist only to detect the end of line and end of frame.
- CAPTURE exit: when the pixel at address WIDTH*HEIGHT-1 is accepted, go to DONE.
- DONE: lasts exactly one cycle, then IDLE.
  - Pixels arriving in DONE or afterwards are dropped.
- frame_start during CAPTURE before the frame completes (short frame):
  - Set short_frame.
  - Reset the address to 0 and stay in CAPTURE (resync).
  - A pix_valid in that same cycle is written at address 0.
- capture_req outside IDLE is ignored.
- Quantization: the top 2 bits of each channel. The index layout matches the 64-entry red/green/blue colour tables.

## Timing
- All outputs are registered.
- Reset values: we=0, waddr=0, wdata=0, busy=0, done=0, short_frame=0, state=IDLE.
- Reset asserted mid-frame aborts immediately; no further writes occur.
- Write latency: pix_valid accepted at cycle t → we/waddr/wdata valid at t+1, for exactly one cycle per pixel.
- done is high in the same cycle as the we of the final pixel (address WIDTH*HEIGHT-1).
- busy:
  - rises the cycle after capture_req;
  - falls in the DONE cycle.
- Gaps in pix_valid are allowed. The address holds and we stays low during a gap.
- Back-to-back pix_valid sustains one write per cycle.
- Address wrap: never exceeds WIDTH*HEIGHT-1; the counter returns to 0 only via frame_start.

## Structure
- Shared package holds:
  - the state enum (IDLE/ARMED/CAPTURE/DONE);
  - the FRAME_PIXELS = WIDTH*HEIGHT constant;
  - the rgb24-to-index6 quantize function. The display side uses the same index layout.
- One sub-module, raster_addr_counter, provides:
  - inputs: clear, increment enable;
  - outputs: linear address, col, row, last_pixel flag.

## Test plan
- Reset mid-CAPTURE at pixel 500 → we drops to 0 within the reset assertion. All outputs return to reset values. state=IDLE after release.
- Normal 320x240 frame, continuous pix_valid, pix_data=0xC08040 → 76800 writes with addresses 0..76799, wdata=6'b111001 (C0→11, 80→10, 40→01). done pulses with the last write. short_frame=0.
- Same frame with random pix_valid gaps (~30% idle) → identical address sequence. No duplicate or skipped addresses. we count = 76800.
- frame_start reasserted after 1000 pixels → short_frame=1. The next write goes to address 0. A full frame then completes with done.
- capture_req pulsed during CAPTURE, then pixels sent after DONE → request ignored, no writes after DONE. busy=0.
- frame_start coincident with pix_valid in ARMED → that pixel appears at waddr=0 one cycle later.

Source files
------------

// File: rtl/frame_capture_writer_pkg.sv
// frame_capture_writer_pkg: shared FSM states, frame geometry defaults and the 6-bit colour index layout.
package frame_capture_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int DEF_WIDTH    = 320;
    localparam int DEF_HEIGHT   = 240;
    localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    // Index layout {R[7:6], G[7:6], B[7:6]} matches the display-side 64-entry colour tables.
    function automatic logic [5:0] quantize(input logic [23:0] rgb);
        return {rgb[23:22], rgb[15:14], rgb[7:6]};
    endfunction

endpackage

// File: rtl/frame_capture_writer_raster_addr_counter.sv
// frame_capture_writer_raster_addr_counter: linear raster address with col/row tracking for end-of-frame detection.
module frame_capture_writer_raster_addr_counter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] w_addr;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_eol;
    logic              w_last;
    logic              w_step;

    // A clear takes effect in the same cycle, so a pixel accepted alongside it uses position 0.
    assign w_addr = i_clear ? '0 : r_addr;
    assign w_col  = i_clear ? '0 : r_col;
    assign w_row  = i_clear ? '0 : r_row;
    assign w_eol  = w_col == COL_W'(WIDTH - 1);
    assign w_last = w_eol && (w_row == ROW_W'(HEIGHT - 1));
    // Saturate on the final pixel; only a clear brings the counter back to 0.
    assign w_step = i_inc && !w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else begin
            r_addr <= w_addr + ADDR_W'(w_step);
            r_col  <= w_step ? (w_eol ? '0 : w_col + 1'b1) : w_col;
            r_row  <= (w_step && w_eol) ? w_row + 1'b1 : w_row;
        end
    end

    assign o_addr = w_addr;
    assign o_col  = w_col;
    assign o_row  = w_row;
    assign o_last = w_last;

endmodule

// File: rtl/frame_capture_writer.sv
// frame_capture_writer: captures one armed frame of RGB888 pixels as 6-bit colour indices
// into the image RAM write port, flagging completion or a short (resynced) frame.
module frame_capture_writer
    import frame_capture_writer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = 17
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic              capture_req,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [5:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic              short_frame
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [5:0]        r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_short;
    logic              w_clear;
    logic              w_wr;
    logic              w_final;
    logic [ADDR_W-1:0] w_addr;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_last;

    assign w_clear = frame_start && (r_state == S_ARMED || r_state == S_CAPTURE);
    assign w_wr    = pix_valid && ((r_state == S_ARMED && frame_start) || r_state == S_CAPTURE);
    assign w_final = w_wr && w_last;

    frame_capture_writer_raster_addr_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_raster_addr_counter (
        .i_clk   (pixel_clk),
        .i_rst_n (rst_n),
        .i_clear (w_clear),
        .i_inc   (w_wr),
        .o_addr  (w_addr),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    // The last-pixel flag must always agree with the raster position.
    always_comb assert (!w_last || (w_col == COL_W'(WIDTH - 1) && w_row == ROW_W'(HEIGHT - 1)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = capture_req ? S_ARMED : S_IDLE;
            S_ARMED:   w_next = frame_start ? (w_final ? S_DONE : S_CAPTURE) : S_ARMED;
            S_CAPTURE: w_next = w_final ? S_DONE : S_CAPTURE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_wr;
            r_done  <= w_final;
            r_busy  <= w_next == S_ARMED || w_next == S_CAPTURE;
            if (w_wr) begin
                r_waddr <= w_addr;
                r_wdata <= quantize(pix_data);
            end
            if (r_state == S_IDLE && capture_req)
                r_short <= 1'b0;
            else if (r_state == S_CAPTURE && frame_start)
                r_short <= 1'b1;
        end
    end

    assign we          = r_we;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign short_frame = r_short;

endmodule
